// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: control-word layout, opcodes and source-count helper.
// Pure types/constants; no timing or flow control of its own.
package sap1_pkg;

    localparam int CW_W = 12;

    localparam int CW_CP   = 11;
    localparam int CW_EP   = 10;
    localparam int CW_LM_N = 9;
    localparam int CW_CE_N = 8;
    localparam int CW_LI_N = 7;
    localparam int CW_EI_N = 6;
    localparam int CW_LA_N = 5;
    localparam int CW_EA   = 4;
    localparam int CW_SU   = 3;
    localparam int CW_EU   = 2;
    localparam int CW_LB_N = 1;
    localparam int CW_LO_N = 0;

    localparam logic [3:0] LDA = 4'd0;
    localparam logic [3:0] ADD = 4'd1;
    localparam logic [3:0] SUB = 4'd2;
    localparam logic [3:0] OUT = 4'd14;
    localparam logic [3:0] HLT = 4'd15;

    // Field order matches the bit indices above, MSB first.
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_n;
        logic ce_n;
        logic li_n;
        logic ei_n;
        logic la_n;
        logic ea;
        logic su;
        logic eu;
        logic lb_n;
        logic lo_n;
    } ctrl_word_t;

    // Number of fetch-unit W-bus sources a control word enables (0..3).
    function automatic logic [1:0] cw_src_count(input ctrl_word_t cw);
        return {1'b0, cw.ep} + {1'b0, ~cw.ce_n} + {1'b0, ~cw.ei_n};
    endfunction

endpackage

// File: rtl/sap1_ram16x8.sv
// Program/data RAM: synchronous write, asynchronous (0-cycle) read, no reset.
// Latency: write visible one edge later; no backpressure, writes always accepted.
module sap1_ram16x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdat,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdat
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/sap1_fetch_unit.sv
// SAP-1 fetch stage: PC, MAR, RAM, IR and the internal W-bus source mux.
// Loads land on the rising edge after the control word; halt/prog_mode freeze state.
module sap1_fetch_unit
    import sap1_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CW_W-1:0]          ctrl_word,
    input  logic                     halt,
    input  logic [DATA_W-1:0]        bus_in,
    input  logic                     prog_mode,
    input  logic                     prog_we,
    input  logic [ADDR_W-1:0]        prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    output logic [DATA_W-ADDR_W-1:0] opcode,
    output logic [DATA_W-1:0]        bus_out,
    output logic                     bus_drive,
    output logic [ADDR_W-1:0]        pc,
    output logic                     bus_conflict
);

    localparam int PAD_W = DATA_W - ADDR_W;

    ctrl_word_t        w_cw;
    logic [1:0]        w_src_cnt;
    logic [DATA_W-1:0] w_ram_dat;
    logic [DATA_W-1:0] w_int_dat;
    logic              w_int_drv;
    logic [DATA_W-1:0] w_eff_bus;
    logic              w_run;
    logic              w_unused;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic              r_conflict;

    assign w_cw      = ctrl_word;
    assign w_src_cnt = cw_src_count(w_cw);
    assign w_run     = !prog_mode && !halt;

    // Accumulator/ALU/output-register controls belong to other datapath blocks.
    assign w_unused = ^{w_cw.la_n, w_cw.ea, w_cw.su, w_cw.eu, w_cw.lb_n, w_cw.lo_n};

    sap1_ram16x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (prog_mode && prog_we),
        .i_waddr (prog_addr),
        .i_wdat  (prog_data),
        .i_raddr (r_mar),
        .o_rdat  (w_ram_dat)
    );

    // Priority Ep > CE > Ei only resolves a conflict; the flag below records it.
    always_comb begin
        w_int_dat = '0;
        w_int_drv = 1'b0;
        if (!prog_mode) begin
            if (w_cw.ep) begin
                w_int_dat = {{PAD_W{1'b0}}, r_pc};
                w_int_drv = 1'b1;
            end else if (!w_cw.ce_n) begin
                w_int_dat = w_ram_dat;
                w_int_drv = 1'b1;
            end else if (!w_cw.ei_n) begin
                w_int_dat = {{PAD_W{1'b0}}, r_ir[ADDR_W-1:0]};
                w_int_drv = 1'b1;
            end
        end
    end

    assign w_eff_bus = w_int_drv ? w_int_dat : bus_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= '0;
            r_mar      <= '0;
            r_ir       <= '0;
            r_conflict <= 1'b0;
        end else begin
            if (!prog_mode && (w_src_cnt >= 2'd2)) begin
                r_conflict <= 1'b1;
            end
            if (w_run) begin
                if (w_cw.cp) begin
                    r_pc <= r_pc + 1'b1;
                end
                if (!w_cw.lm_n) begin
                    r_mar <= w_eff_bus[ADDR_W-1:0];
                end
                if (!w_cw.li_n) begin
                    r_ir <= w_eff_bus;
                end
            end
        end
    end

    assign opcode       = r_ir[DATA_W-1:ADDR_W];
    assign bus_out      = w_int_dat;
    assign bus_drive    = w_int_drv;
    assign pc           = r_pc;
    assign bus_conflict = r_conflict;

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// Directed bench for sap1_fetch_unit: vector table for the fetch path plus
// hand-written sequences for wrap, prog mode, conflict and async reset.
module tb_sap1_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [11:0] ctrl_word;
    logic        halt;
    logic [7:0]  bus_in;
    logic        prog_mode;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  opcode;
    logic [7:0]  bus_out;
    logic        bus_drive;
    logic [3:0]  pc;
    logic        bus_conflict;

    int checks = 0;
    int errors = 0;

    sap1_fetch_unit #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ctrl_word    (ctrl_word),
        .halt         (halt),
        .bus_in       (bus_in),
        .prog_mode    (prog_mode),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .opcode       (opcode),
        .bus_out      (bus_out),
        .bus_drive    (bus_drive),
        .pc           (pc),
        .bus_conflict (bus_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_mode = 1'b1;
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [11:0] cw);
        @(negedge clk);
        ctrl_word = cw;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [11:0] cw;
        logic        hlt;
        logic [7:0]  exp_bus;
        logic        exp_drv;
        logic [3:0]  exp_pc;
        logic [3:0]  exp_mar;
        logic [7:0]  exp_ir;
    } vec_t;

    vec_t vecs[11];
    vec_t v;
    logic [7:0] exp_ir_v;

    initial begin
        // cw       halt bus_out drv pc  mar  ir
        vecs[0]  = '{12'h5E3, 1'b0, 8'h00, 1'b1, 4'd0, 4'h0, 8'h00}; // Ep, Lm
        vecs[1]  = '{12'hBE3, 1'b0, 8'h00, 1'b0, 4'd1, 4'h0, 8'h00}; // Cp
        vecs[2]  = '{12'h263, 1'b0, 8'h19, 1'b1, 4'd1, 4'h0, 8'h19}; // CE, Li
        vecs[3]  = '{12'h1A3, 1'b0, 8'h09, 1'b1, 4'd1, 4'h9, 8'h19}; // Ei, Lm
        vecs[4]  = '{12'h2C3, 1'b0, 8'h2A, 1'b1, 4'd1, 4'h9, 8'h19}; // CE, La
        vecs[5]  = '{12'hDE3, 1'b0, 8'h01, 1'b1, 4'd2, 4'h1, 8'h19}; // Ep, Lm, Cp
        vecs[6]  = '{12'h263, 1'b0, 8'hF0, 1'b1, 4'd2, 4'h1, 8'hF0};
        vecs[7]  = '{12'hB63, 1'b1, 8'h00, 1'b0, 4'd2, 4'h1, 8'hF0}; // halted Cp, Li
        vecs[8]  = '{12'h163, 1'b0, 8'h00, 1'b0, 4'd2, 4'h7, 8'h77}; // Lm, Li from bus_in
        vecs[9]  = '{12'h2C3, 1'b0, 8'h3C, 1'b1, 4'd2, 4'h7, 8'h77};
        vecs[10] = '{12'h0E3, 1'b0, 8'h3C, 1'b1, 4'd2, 4'hC, 8'h77}; // CE, Lm

        reset_n   = 1'b0;
        ctrl_word = 12'h3E3;
        halt      = 1'b0;
        bus_in    = 8'h77;
        prog_mode = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;

        prog_write(4'd0, 8'h19);
        prog_write(4'd1, 8'hF0);
        prog_write(4'd7, 8'h3C);
        prog_write(4'd9, 8'h2A);

        @(negedge clk);
        prog_mode = 1'b0;
        prog_we   = 1'b0;
        #1;
        chk("reset_pc", 32'(pc), 32'h0);
        chk("reset_mar", 32'(dut.r_mar), 32'h0);
        chk("reset_ir", 32'(dut.r_ir), 32'h0);
        chk("reset_opcode", 32'(opcode), 32'h0);
        chk("reset_conflict", 32'(bus_conflict), 32'h0);
        chk("reset_idle_drive", 32'(bus_drive), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            @(negedge clk);
            ctrl_word = v.cw;
            halt      = v.hlt;
            #1;
            chk($sformatf("vec%0d_bus_out", i), 32'(bus_out), 32'(v.exp_bus));
            chk($sformatf("vec%0d_bus_drive", i), 32'(bus_drive), 32'(v.exp_drv));
            @(posedge clk);
            #1;
            exp_ir_v = v.exp_ir;
            chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(v.exp_pc));
            chk($sformatf("vec%0d_mar", i), 32'(dut.r_mar), 32'(v.exp_mar));
            chk($sformatf("vec%0d_ir", i), 32'(dut.r_ir), 32'(exp_ir_v));
            chk($sformatf("vec%0d_opcode", i), 32'(opcode), 32'(exp_ir_v[7:4]));
        end
        @(negedge clk);
        halt = 1'b0;
        chk("no_conflict_yet", 32'(bus_conflict), 32'h0);

        // PC wrap and combined Ep+Lm+Cp at the top of the address space
        for (int i = 0; i < 13; i++) apply(12'hBE3);
        chk("pc_at_15", 32'(pc), 32'hF);
        apply(12'hDE3);
        chk("wrap_mar_old_pc", 32'(dut.r_mar), 32'hF);
        chk("wrap_pc_zero", 32'(pc), 32'h0);

        // prog_mode: write RAM[15], PC frozen, bus quiet, no conflict recorded
        @(negedge clk);
        prog_mode = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'hF;
        prog_data = 8'hA5;
        ctrl_word = 12'hBE3;
        @(posedge clk);
        #1;
        chk("prog_pc_hold", 32'(pc), 32'h0);
        @(negedge clk);
        prog_we   = 1'b0;
        ctrl_word = 12'h6E3;
        #1;
        chk("prog_bus_out", 32'(bus_out), 32'h0);
        chk("prog_bus_drive", 32'(bus_drive), 32'h0);
        @(posedge clk);
        #1;
        chk("prog_no_conflict", 32'(bus_conflict), 32'h0);
        chk("prog_pc_hold2", 32'(pc), 32'h0);

        @(negedge clk);
        prog_mode = 1'b0;
        ctrl_word = 12'h2E3;
        #1;
        chk("ram_write_readback", 32'(bus_out), 32'hA5);

        // Ep and CE together: Ep wins the bus, sticky conflict
        @(negedge clk);
        ctrl_word = 12'h6E3;
        #1;
        chk("conflict_bus_is_pc", 32'(bus_out), 32'h00);
        chk("conflict_drive", 32'(bus_drive), 32'h1);
        chk("conflict_before_edge", 32'(bus_conflict), 32'h0);
        @(posedge clk);
        #1;
        chk("conflict_set", 32'(bus_conflict), 32'h1);
        apply(12'h3E3);
        chk("conflict_sticky", 32'(bus_conflict), 32'h1);

        // IR=0xF0 from bus_in, then async reset between edges
        @(negedge clk);
        bus_in    = 8'hF0;
        ctrl_word = 12'hB63;
        @(posedge clk);
        #1;
        chk("hlt_opcode_loaded", 32'(opcode), 32'hF);
        chk("pc_before_reset", 32'(pc), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_ir", 32'(dut.r_ir), 32'h0);
        chk("async_opcode", 32'(opcode), 32'h0);
        chk("async_pc", 32'(pc), 32'h0);
        chk("async_mar", 32'(dut.r_mar), 32'h0);
        chk("async_conflict", 32'(bus_conflict), 32'h0);
        ctrl_word = 12'h5E3;
        #0.5;
        chk("reset_bus_drive_comb", 32'(bus_drive), 32'h1);
        @(negedge clk);
        reset_n   = 1'b1;
        ctrl_word = 12'h2E3;
        #1;
        chk("ram0_survives_reset", 32'(bus_out), 32'h19);
        @(negedge clk);
        bus_in    = 8'h0F;
        ctrl_word = 12'h1E3;
        @(posedge clk);
        #1;
        chk("mar_from_bus_in", 32'(dut.r_mar), 32'hF);
        @(negedge clk);
        ctrl_word = 12'h2E3;
        #1;
        chk("ram15_survives_reset", 32'(bus_out), 32'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
